lsu: RTL and testbench

Load/store unit replacing the core's direct single-cycle data-memory wiring. Accepts one load or store per handshake from the core and handles byte/half/word (and doubleword at 64-bit) accesses with byte enables and sign/zero extension. Talks to a variable-latency data memory over a ce/ready handshake, and detects misaligned, illegal and timed-out accesses. Sits between the core's EX/MEM boundary and the external data memory port.

---
 rtl/riscv_lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 94 +++++++++
 rtl/lsu.sv | 145 ++++++++++++++
 tb/tb_lsu.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the load/store unit: RISC-V funct3 access codes,
// response error codes and the FSM state type.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: funct3 legality, alignment check,
// byte enables, store lane shift and load extract/extend (little-endian).
module lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic                                  we,
  input  logic [2:0]                            funct3,
  input  logic [$clog2(WORD_BITWIDTH/8)-1:0]    lane,
  input  logic [WORD_BITWIDTH-1:0]              wdata,
  input  logic [WORD_BITWIDTH-1:0]              rdata,
  output logic [1:0]                            err,
  output logic [WORD_BITWIDTH/8-1:0]            be,
  output logic [WORD_BITWIDTH-1:0]              wdata_lane,
  output logic [WORD_BITWIDTH-1:0]              rdata_ext
);

  localparam int BW = WORD_BITWIDTH / 8;
  localparam int LB = $clog2(BW);
  localparam logic [WORD_BITWIDTH-1:0] ONE_W = {{(WORD_BITWIDTH-1){1'b0}}, 1'b1};

  logic [1:0]               size_s;
  logic                     legal_s;
  logic                     misalign_s;
  logic [LB-1:0]            amask_s;
  logic [BW-1:0]            mask_s;
  logic [WORD_BITWIDTH-1:0] sh_s;
  logic [WORD_BITWIDTH-1:0] low_s;
  logic                     sign_s;

  // funct3[1:0] is log2 of the access size in bytes for every legal code
  assign size_s = funct3[1:0];

  // Which funct3 codes exist for this direction and word width
  always_comb begin
    legal_s = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal_s = 1'b1;
      F3_D:             legal_s = (WORD_BITWIDTH == 64);
      F3_BU, F3_HU:     legal_s = ~we;
      F3_WU:            legal_s = ~we & (WORD_BITWIDTH == 64);
      default:          legal_s = 1'b0;
    endcase
  end

  // Size-derived masks: lane bits that must be zero, and unshifted byte enables
  always_comb begin
    amask_s = LB'((32'd1 << size_s) - 32'd1);
    if (size_s == 2'd3) begin
      mask_s = '1;
    end else begin
      mask_s = BW'((32'd1 << (32'd1 << size_s)) - 32'd1);
    end
  end

  assign misalign_s = |(lane & amask_s);

  // Illegal funct3 outranks misalignment
  always_comb begin
    if (!legal_s) begin
      err = ERR_ILLEGAL;
    end else if (misalign_s) begin
      err = ERR_MISALIGN;
    end else begin
      err = ERR_OK;
    end
  end

  assign be         = mask_s << lane;
  assign wdata_lane = wdata << {lane, 3'b000};
  assign sh_s       = rdata >> {lane, 3'b000};

  // Extract the addressed bytes and extend; funct3[2] selects zero-extension
  always_comb begin
    case (size_s)
      2'd0:    sign_s = sh_s[7];
      2'd1:    sign_s = sh_s[15];
      2'd2:    sign_s = sh_s[31];
      default: sign_s = 1'b0;
    endcase
    if (size_s == 2'd3) begin
      low_s = '1;
    end else begin
      low_s = (ONE_W << (32'd8 << size_s)) - ONE_W;
    end
    if (funct3[2] || !sign_s) begin
      rdata_ext = sh_s & low_s;
    end else begin
      rdata_ext = (sh_s & low_s) | ~low_s;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request in flight, IDLE -> ACCESS -> RESP handshake
// against a variable-latency data memory with timeout and error reporting.
module lsu
  import riscv_lsu_pkg::*;
#(
  parameter int WORD_BITWIDTH  = 32,
  parameter int ADDR_BITWIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [ADDR_BITWIDTH-1:0]   req_addr_i,
  input  logic [WORD_BITWIDTH-1:0]   req_wdata_i,
  output logic                       resp_valid_o,
  output logic [WORD_BITWIDTH-1:0]   resp_rdata_o,
  output logic [1:0]                 resp_err_o,
  output logic                       data_ce_o,
  output logic                       data_we_o,
  output logic [WORD_BITWIDTH/8-1:0] data_be_o,
  output logic [ADDR_BITWIDTH-1:0]   data_addr_o,
  output logic [WORD_BITWIDTH-1:0]   data_o,
  input  logic [WORD_BITWIDTH-1:0]   data_i,
  input  logic                       data_ready_i
);

  localparam int BW = WORD_BITWIDTH / 8;
  localparam int LB = $clog2(BW);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e               state_r;
  logic [2:0]               funct3_r;
  logic [LB-1:0]            lane_r;
  logic [CW-1:0]            cnt_r;
  logic [2:0]               funct3_s;
  logic [LB-1:0]            lane_s;
  logic [1:0]               err_s;
  logic [BW-1:0]            be_s;
  logic [WORD_BITWIDTH-1:0] wdata_s;
  logic [WORD_BITWIDTH-1:0] rdata_s;

  // The checker sees the live request while idle and the latched one afterwards
  always_comb begin
    if (state_r == S_IDLE) begin
      funct3_s = req_funct3_i;
      lane_s   = req_addr_i[LB-1:0];
    end else begin
      funct3_s = funct3_r;
      lane_s   = lane_r;
    end
  end

  lsu_align #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_align (
    .we         (req_we_i),
    .funct3     (funct3_s),
    .lane       (lane_s),
    .wdata      (req_wdata_i),
    .rdata      (data_i),
    .err        (err_s),
    .be         (be_s),
    .wdata_lane (wdata_s),
    .rdata_ext  (rdata_s)
  );

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      funct3_r     <= 3'b000;
      lane_r       <= '0;
      cnt_r        <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= ERR_OK;
      data_ce_o    <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_o       <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid_i) begin
            funct3_r    <= req_funct3_i;
            lane_r      <= req_addr_i[LB-1:0];
            cnt_r       <= '0;
            req_ready_o <= 1'b0;
            if (err_s != ERR_OK) begin
              state_r      <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= err_s;
              resp_rdata_o <= '0;
            end else begin
              state_r     <= S_ACCESS;
              data_ce_o   <= 1'b1;
              data_we_o   <= req_we_i;
              data_be_o   <= be_s;
              data_addr_o <= {req_addr_i[ADDR_BITWIDTH-1:LB], {LB{1'b0}}};
              data_o      <= req_we_i ? wdata_s : '0;
            end
          end
        end
        S_ACCESS: begin
          // A ready on the last counted cycle still completes normally
          if (data_ready_i) begin
            state_r      <= S_RESP;
            data_ce_o    <= 1'b0;
            data_we_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= ERR_OK;
            resp_rdata_o <= data_we_o ? '0 : rdata_s;
          end else if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
            state_r      <= S_RESP;
            data_ce_o    <= 1'b0;
            data_we_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= ERR_TIMEOUT;
            resp_rdata_o <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_RESP: begin
          state_r      <= S_IDLE;
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          resp_err_o   <= ERR_OK;
          resp_rdata_o <= '0;
        end
        default: begin
          state_r      <= S_IDLE;
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          data_ce_o    <= 1'b0;
          data_we_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a 32-bit and a 64-bit instance (both TIMEOUT_CYCLES=4)
// driven from one request bus, checked against hand-computed vectors.
module tb_lsu;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [63:0] req_wdata = 64'h0;
  logic [63:0] mem_rdata = 64'h0;
  logic        mem_ready = 1'b0;

  logic        rr32, rv32, ce32, we32, rr64, rv64, ce64, we64;
  logic [31:0] rd32, do32, ad32, ad64;
  logic [1:0]  er32, er64;
  logic [3:0]  be32;
  logic [63:0] rd64, do64;
  logic [7:0]  be64;

  logic        o_rr, o_rv, o_ce, o_we;
  logic [31:0] o_addr;
  logic [63:0] o_rd, o_do;
  logic [1:0]  o_err;
  logic [7:0]  o_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu #(.WORD_BITWIDTH(32), .ADDR_BITWIDTH(32), .TIMEOUT_CYCLES(4)) u_lsu32 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(rr32),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata[31:0]), .resp_valid_o(rv32), .resp_rdata_o(rd32),
    .resp_err_o(er32), .data_ce_o(ce32), .data_we_o(we32), .data_be_o(be32),
    .data_addr_o(ad32), .data_o(do32), .data_i(mem_rdata[31:0]), .data_ready_i(mem_ready)
  );

  lsu #(.WORD_BITWIDTH(64), .ADDR_BITWIDTH(32), .TIMEOUT_CYCLES(4)) u_lsu64 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid & sel), .req_ready_o(rr64),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(rv64), .resp_rdata_o(rd64),
    .resp_err_o(er64), .data_ce_o(ce64), .data_we_o(we64), .data_be_o(be64),
    .data_addr_o(ad64), .data_o(do64), .data_i(mem_rdata), .data_ready_i(mem_ready)
  );

  always_comb begin
    if (sel) begin
      {o_rr, o_rv, o_ce, o_we} = {rr64, rv64, ce64, we64};
      o_addr = ad64; o_rd = rd64; o_do = do64; o_err = er64; o_be = be64;
    end else begin
      {o_rr, o_rv, o_ce, o_we} = {rr32, rv32, ce32, we32};
      o_addr = ad32; o_rd = {32'h0, rd32}; o_do = {32'h0, do32}; o_err = er32; o_be = {4'h0, be32};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; ready_at = ACCESS cycle (1-based) with data_ready, 0 = never
  task automatic run(input string tag, input logic use64, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] mem,
                     input int ready_at, input int exp_ce, input logic [31:0] exp_addr,
                     input logic [7:0] exp_be, input logic [63:0] exp_do,
                     input logic [1:0] exp_err, input logic [63:0] exp_rd);
    int k;
    int ce_n;
    ce_n = 0;
    k = 1;
    @(negedge clk);
    sel = use64; req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, "/busy"}, {63'h0, o_rr}, 64'h0);
    while (o_ce && k <= 20) begin
      if (k == 1) begin
        check_eq({tag, "/addr"}, {32'h0, o_addr}, {32'h0, exp_addr});
        check_eq({tag, "/be"}, {56'h0, o_be}, {56'h0, exp_be});
        check_eq({tag, "/wdata"}, o_do, exp_do);
        check_eq({tag, "/we"}, {63'h0, o_we}, {63'h0, we});
      end
      if (k == ready_at) begin
        mem_ready = 1'b1; mem_rdata = mem;
      end else begin
        mem_ready = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      ce_n++;
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0;
    check_eq({tag, "/ce_cycles"}, 64'(ce_n), 64'(exp_ce));
    check_eq({tag, "/resp_valid"}, {63'h0, o_rv}, 64'h1);
    check_eq({tag, "/err"}, {62'h0, o_err}, {62'h0, exp_err});
    check_eq({tag, "/rdata"}, o_rd, exp_rd);
    @(negedge clk);
    check_eq({tag, "/resp_drop"}, {63'h0, o_rv}, 64'h0);
    check_eq({tag, "/ready_back"}, {63'h0, o_rr}, 64'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check_eq({tag, "/ready"}, {63'h0, o_rr}, 64'h1);
      check_eq({tag, "/ctl"}, {61'h0, o_rv, o_ce, o_we}, 64'h0);
      check_eq({tag, "/be_addr"}, {24'h0, o_be, o_addr}, 64'h0);
      check_eq({tag, "/data"}, o_do | o_rd, 64'h0);
      check_eq({tag, "/err"}, {62'h0, o_err}, 64'h0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // 32-bit instance
    run("sb_103",  1'b0, 1'b1, F3_B,  32'h103, 64'h0000_00AB, 64'h0, 1, 1,
        32'h100, 8'h08, 64'h0000_0000_AB00_0000, ERR_OK, 64'h0);
    run("lh_102",  1'b0, 1'b0, F3_H,  32'h102, 64'h0, 64'h8001_0000, 1, 1,
        32'h100, 8'h0C, 64'h0, ERR_OK, 64'hFFFF_8001);
    run("lhu_102", 1'b0, 1'b0, F3_HU, 32'h102, 64'h0, 64'h8001_0000, 1, 1,
        32'h100, 8'h0C, 64'h0, ERR_OK, 64'h0000_8001);
    run("lw_mis",  1'b0, 1'b0, F3_W,  32'h101, 64'h0, 64'h0, 1, 0,
        32'h0, 8'h00, 64'h0, ERR_MISALIGN, 64'h0);
    run("f3_111",  1'b0, 1'b0, 3'b111, 32'h100, 64'h0, 64'h0, 1, 0,
        32'h0, 8'h00, 64'h0, ERR_ILLEGAL, 64'h0);
    run("lw_tmo",  1'b0, 1'b0, F3_W,  32'h200, 64'h0, 64'h0, 0, 4,
        32'h200, 8'h0F, 64'h0, ERR_TIMEOUT, 64'h0);
    run("lw_last", 1'b0, 1'b0, F3_W,  32'h200, 64'h0, 64'h1234_5678, 4, 4,
        32'h200, 8'h0F, 64'h0, ERR_OK, 64'h1234_5678);
    run("lb_101",  1'b0, 1'b0, F3_B,  32'h101, 64'h0, 64'h0000_8000, 2, 2,
        32'h100, 8'h02, 64'h0, ERR_OK, 64'hFFFF_FF80);
    run("sh_106",  1'b0, 1'b1, F3_H,  32'h106, 64'hFFFF_1234, 64'h0, 1, 1,
        32'h104, 8'h0C, 64'h0000_0000_1234_0000, ERR_OK, 64'h0);
    run("sd_on32", 1'b0, 1'b1, F3_D,  32'h101, 64'h0, 64'h0, 1, 0,
        32'h0, 8'h00, 64'h0, ERR_ILLEGAL, 64'h0);

    // 64-bit instance
    run("sd_8",    1'b1, 1'b1, F3_D,  32'h8, 64'h0102_0304_0506_0708, 64'h0, 1, 1,
        32'h8, 8'hFF, 64'h0102_0304_0506_0708, ERR_OK, 64'h0);
    run("lwu_4",   1'b1, 1'b0, F3_WU, 32'h4, 64'h0, 64'hFFFF_FFFF_0000_0000, 1, 1,
        32'h0, 8'hF0, 64'h0, ERR_OK, 64'h0000_0000_FFFF_FFFF);
    run("lw_4",    1'b1, 1'b0, F3_W,  32'h4, 64'h0, 64'hFFFF_FFFF_0000_0000, 1, 1,
        32'h0, 8'hF0, 64'h0, ERR_OK, 64'hFFFF_FFFF_FFFF_FFFF);
    run("ld_mis",  1'b1, 1'b0, F3_D,  32'h4, 64'h0, 64'h0, 1, 0,
        32'h0, 8'h00, 64'h0, ERR_MISALIGN, 64'h0);
    run("lb_7",    1'b1, 1'b0, F3_B,  32'h7, 64'h0, 64'h7F00_0000_0000_0000, 1, 1,
        32'h0, 8'h80, 64'h0, ERR_OK, 64'h7F);

    // Reset in the second ACCESS cycle abandons the access silently
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W;
    req_addr = 32'h300; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rst_mid/ce1", {63'h0, o_ce}, 64'h1);
    @(negedge clk);
    check_eq("rst_mid/ce2", {63'h0, o_ce}, 64'h1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    sel = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid/no_resp", {63'h0, o_rv}, 64'h0);
    run("after_rst", 1'b0, 1'b0, F3_BU, 32'h302, 64'h0, 64'h00C3_0000, 1, 1,
        32'h300, 8'h04, 64'h0, ERR_OK, 64'h0000_00C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
